// File: rtl/finite_log.sv
// Sequential discrete logarithm over GF(2^M): walks alpha^count through the
// multiplicative group and tests PAR consecutive powers per cycle against the target.
module finite_log #(
   parameter int unsigned M   = 4,
   parameter int unsigned PAR = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [M-1:0] standard_in,
   output logic         busy,
   output logic         done,
   output logic [M-1:0] log_out,
   output logic         zero,
   output logic         error
);

   // Extra bit so count+j and count+PAR cannot overflow before the range check.
   localparam int unsigned CW = M + 1;

   // Primitive field polynomials, x^M term included.
   function automatic int unsigned poly_full(input int unsigned m);
      case (m)
         2:       return 32'h0000_0007;
         3:       return 32'h0000_000B;
         4:       return 32'h0000_0013;
         5:       return 32'h0000_0025;
         6:       return 32'h0000_0043;
         7:       return 32'h0000_0089;
         8:       return 32'h0000_011D;
         9:       return 32'h0000_0211;
         10:      return 32'h0000_0409;
         11:      return 32'h0000_0805;
         12:      return 32'h0000_1053;
         13:      return 32'h0000_201B;
         14:      return 32'h0000_4443;
         15:      return 32'h0000_8003;
         16:      return 32'h0001_100B;
         default: return 32'h0000_0000;
      endcase
   endfunction

   localparam logic [M-1:0]  POLY = M'(poly_full(M));
   localparam logic [CW-1:0] LAST = CW'((1 << M) - 2);
   localparam logic [CW-1:0] STEP = CW'(PAR);

   // Multiply a standard-basis element by alpha.
   function automatic logic [M-1:0] mul1(input logic [M-1:0] a);
      return {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY : '0);
   endfunction

   typedef enum logic {IDLE, SEARCH} state_t;

   state_t       state;
   logic [M-1:0] target;
   logic [M-1:0] acc;
   logic [M-1:0] count;

   logic [M-1:0]  walk_c;
   logic [M-1:0]  step_c;
   logic          hit_c;
   logic [M-1:0]  hit_k_c;
   logic          exhaust_c;
   logic [CW-1:0] idx_c;

   // Candidate chain with lowest-index priority; only exponents up to 2^M-2 count.
   always_comb begin
      walk_c    = acc;
      hit_c     = 1'b0;
      hit_k_c   = '0;
      idx_c     = '0;
      for (int j = 0; j < int'(PAR); j++) begin
         idx_c = CW'(count) + CW'(j);
         if (!hit_c && (idx_c <= LAST) && (walk_c == target)) begin
            hit_c   = 1'b1;
            hit_k_c = M'(idx_c);
         end
         walk_c = mul1(walk_c);
      end
      step_c    = walk_c;
      exhaust_c = (CW'(count) + STEP) > LAST;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         target  <= '0;
         acc     <= M'(1);
         count   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         log_out <= '0;
         zero    <= 1'b0;
         error   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (standard_in == '0) begin
                     done    <= 1'b1;
                     zero    <= 1'b1;
                     error   <= 1'b0;
                     log_out <= '0;
                  end else begin
                     target <= standard_in;
                     acc    <= M'(1);
                     count  <= '0;
                     zero   <= 1'b0;
                     error  <= 1'b0;
                     busy   <= 1'b1;
                     state  <= SEARCH;
                  end
               end
            end
            SEARCH: begin
               if (hit_c) begin
                  log_out <= hit_k_c;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else if (exhaust_c) begin
                  // Unreachable with a primitive polynomial; guards a bad table entry.
                  log_out <= '1;
                  error   <= 1'b1;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  acc   <= step_c;
                  count <= M'(CW'(count) + STEP);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_finite_log.sv
// Directed bench for finite_log at M=4 (x^4+x+1) with PAR = 1, 4, 3 and 15.
module tb_finite_log;

   logic       clk;
   logic       reset;
   logic [3:0] start;
   logic [3:0] din [4];
   logic [3:0] busy;
   logic [3:0] done;
   logic [3:0] zero;
   logic [3:0] error;
   logic [3:0] lg  [4];

   int checks = 0;
   int errors = 0;
   int logtab [16];
   int par_of [4] = '{1, 4, 3, 15};

   finite_log #(.M(4), .PAR(1)) u_p1 (
      .clk(clk), .reset(reset), .start(start[0]), .standard_in(din[0]),
      .busy(busy[0]), .done(done[0]), .log_out(lg[0]), .zero(zero[0]), .error(error[0]));
   finite_log #(.M(4), .PAR(4)) u_p4 (
      .clk(clk), .reset(reset), .start(start[1]), .standard_in(din[1]),
      .busy(busy[1]), .done(done[1]), .log_out(lg[1]), .zero(zero[1]), .error(error[1]));
   finite_log #(.M(4), .PAR(3)) u_p3 (
      .clk(clk), .reset(reset), .start(start[2]), .standard_in(din[2]),
      .busy(busy[2]), .done(done[2]), .log_out(lg[2]), .zero(zero[2]), .error(error[2]));
   finite_log #(.M(4), .PAR(15)) u_p15 (
      .clk(clk), .reset(reset), .start(start[3]), .standard_in(din[3]),
      .busy(busy[3]), .done(done[3]), .log_out(lg[3]), .zero(zero[3]), .error(error[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference: alpha^k with alpha^4 = x + 1.
   function automatic logic [3:0] lpow(input int k);
      logic [3:0] a;
      a = 4'b0001;
      for (int i = 0; i < k; i++) a = {a[2:0], 1'b0} ^ (a[3] ? 4'b0011 : 4'b0000);
      return a;
   endfunction

   // Entered and left #1 after a rising edge; lat counts edges after the accepting one.
   task automatic run_op(input int u, input logic [3:0] val, input int poke,
                         output int lat, output int k, output int z, output int e,
                         output int bcnt);
      int n;
      start[u] = 1'b1;
      din[u]   = val;
      @(posedge clk); #1;
      start[u] = 1'b0;
      lat  = -1;
      bcnt = 0;
      n    = 0;
      while (lat < 0 && n <= 40) begin
         if (done[u]) begin
            lat = n;
         end else begin
            if (busy[u]) bcnt++;
            if (n == poke - 1) begin
               start[u] = 1'b1;
               din[u]   = 4'b0001;
            end else if (n == poke) begin
               start[u] = 1'b0;
            end
            @(posedge clk); #1;
            n++;
         end
      end
      if (lat < 0) check($sformatf("timeout_u%0d_in%0d", u, val), n, 0);
      else check($sformatf("busy_at_done_u%0d_in%0d", u, val), int'(busy[u]), 0);
      k = int'(lg[u]);
      z = int'(zero[u]);
      e = int'(error[u]);
   endtask

   task automatic sweep(input int u);
      int lat, k, z, e, b, exp_k;
      for (int v = 1; v < 16; v++) begin
         run_op(u, 4'(v), -1, lat, k, z, e, b);
         exp_k = logtab[v];
         check($sformatf("p%0d_log_in%0d", par_of[u], v), k, exp_k);
         check($sformatf("p%0d_lat_in%0d", par_of[u], v), lat, exp_k / par_of[u] + 1);
         check($sformatf("p%0d_busy_in%0d", par_of[u], v), b, lat);
         check($sformatf("p%0d_err_in%0d", par_of[u], v), e, 0);
         check($sformatf("p%0d_zero_in%0d", par_of[u], v), z, 0);
         if (u == 1 && v == 9) check("p4_1001_lat_hand", lat, 4);
      end
   endtask

   initial begin
      int lat, k, z, e, b, dcnt, bcnt;
      for (int i = 0; i < 16; i++) logtab[i] = 0;
      for (int i = 0; i < 15; i++) logtab[lpow(i)] = i;
      start = '0;
      for (int i = 0; i < 4; i++) din[i] = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_zero", int'(zero), 0);
      check("rst_error", int'(error), 0);
      for (int i = 0; i < 4; i++) check($sformatf("rst_log_u%0d", i), int'(lg[i]), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Reset asserted mid-search on 1001 must abandon it silently.
      start[0] = 1'b1;
      din[0]   = 4'b1001;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("mid_busy_before_rst", int'(busy[0]), 1);
      #3 reset = 1'b1;
      #1;
      check("mid_rst_busy", int'(busy[0]), 0);
      check("mid_rst_done", int'(done[0]), 0);
      check("mid_rst_log", int'(lg[0]), 0);
      @(posedge clk); #2;
      reset = 1'b0;
      @(posedge clk); #1;
      dcnt = 0;
      bcnt = 0;
      repeat (20) begin
         if (done[0]) dcnt++;
         if (busy[0]) bcnt++;
         @(posedge clk); #1;
      end
      check("post_rst_no_done", dcnt, 0);
      check("post_rst_no_busy", bcnt, 0);

      // PAR=1 directed vectors.
      run_op(0, 4'b0001, -1, lat, k, z, e, b);
      check("p1_0001_lat", lat, 1);
      check("p1_0001_log", k, 0);
      check("p1_0001_zero", z, 0);
      run_op(0, 4'b0010, -1, lat, k, z, e, b);
      check("p1_0010_lat", lat, 2);
      check("p1_0010_log", k, 1);
      repeat (2) @(posedge clk);
      #1;
      run_op(0, 4'b1001, 5, lat, k, z, e, b);
      check("p1_1001_lat", lat, 15);
      check("p1_1001_log", k, 14);
      check("p1_1001_busy", b, 15);
      check("p1_1001_err", e, 0);
      repeat (2) @(posedge clk);
      #1;
      check("p1_idle_after_poke", int'(busy[0]), 0);
      run_op(0, 4'b0000, -1, lat, k, z, e, b);
      check("p1_zero_lat", lat, 0);
      check("p1_zero_flag", z, 1);
      check("p1_zero_log", k, 0);
      check("p1_zero_busy", b, 0);
      run_op(0, 4'b0011, -1, lat, k, z, e, b);
      check("p1_0011_lat", lat, 5);
      check("p1_0011_log", k, 4);
      check("p1_0011_zero", z, 0);

      // Full sweeps, back to back within each PAR.
      sweep(1);
      sweep(2);
      sweep(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck, expected finish");
      $fatal(1);
   end

endmodule
